cordic_arbiter: RTL

Shares one pipelined CORDIC_Algorithm instance between N_REQ independent requesters (e.g. the text-overlay value updater, sweep generators, diagnostics) on the CORDIC clock domain. Round-robin arbitration selects one request per cycle, drives the CORDIC input side, and keeps an in-order tag FIFO. Each result is routed back to the requester that issued it. Sits between the requesters and the CORDIC core and replaces hard-wired initial values on the CORDIC inputs.

---
 rtl/cordic_pkg.sv | 23 ++
 rtl/cordic_tag_fifo.sv | 44 ++++
 rtl/cordic_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC operand width, mode constants and request/response payload types.
package cordic_pkg;
  localparam int INT_BITS = 3;
  localparam int FRACTIONAL_BITS = 30;
  localparam int CORDIC_BITS = INT_BITS + FRACTIONAL_BITS;
  localparam logic signed [1:0] HYPERBOLIC = -2'sd1;
  localparam logic signed [1:0] LINEAR = 2'sd0;
  localparam logic signed [1:0] CIRCULAR = 2'sd1;
  typedef struct packed {
    logic signed [CORDIC_BITS-1:0] x;
    logic signed [CORDIC_BITS-1:0] y;
    logic signed [CORDIC_BITS-1:0] z;
    logic signed [1:0] mode;
    logic rot_en;
  } cordic_req_t;
  typedef struct packed {
    logic signed [CORDIC_BITS-1:0] x;
    logic signed [CORDIC_BITS-1:0] y;
    logic signed [CORDIC_BITS-1:0] z;
    logic signed [1:0] mode;
    logic rot_en;
  } cordic_rsp_t;
endpackage

// File: rtl/cordic_tag_fifo.sv
// cordic_tag_fifo: in-order requester-index FIFO; push ignored when full, pop ignored when empty.
module cordic_tag_fifo #(
  parameter int W = 2,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  always_comb begin
    push_ok = i_push && !o_full;
    pop_ok = i_pop && !o_empty;
    wr_d = wr_q + AW'(push_ok);
    rd_d = rd_q + AW'(pop_ok);
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge i_clk)
    if (push_ok) mem_q[wr_q] <= i_data;
  assign o_data = mem_q[rd_q];
  assign o_empty = cnt_q == '0;
  assign o_full = cnt_q == (AW+1)'(DEPTH);
  assign o_count = cnt_q;
endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin sharing of one pipelined CORDIC core with in-order response routing.
// Define CORDIC_ARB_PERF_EN to build saturating per-requester grant counters.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BITS = 33,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_W = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [N_REQ-1:0]              i_req_valid,
  output logic [N_REQ-1:0]              o_req_ready,
  input  cordic_req_t [N_REQ-1:0]       i_req,
  output logic [N_REQ-1:0]              o_rsp_valid,
  output cordic_rsp_t                   o_rsp,
  output logic                          o_cordic_ready,
  output cordic_req_t                   o_cordic_req,
  input  logic                          i_cordic_valid,
  input  cordic_rsp_t                   i_cordic_rsp,
  output logic                          o_busy,
  output logic                          o_err,
  output logic [N_REQ-1:0][CNT_W-1:0]   o_grant_count
);
  localparam int TW = $clog2(N_REQ);
  localparam int AW = $clog2(MAX_OUTSTANDING);
  if (BITS != CORDIC_BITS) begin : g_bits_check
    $error("cordic_arbiter: BITS must equal cordic_pkg::CORDIC_BITS");
  end
  logic [TW-1:0] rr_q, rr_d, off, gnt_idx, tag;
  logic [TW:0] gsum;
  logic [2*N_REQ-1:0] dbl;
  logic any, grant, full, empty, pop;
  logic [AW:0] count;
  cordic_req_t creq_q, creq_d;
  cordic_rsp_t rsp_q, rsp_d;
  logic cready_q, cready_d, err_q, err_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  // Rotate valids so bit 0 is rr_ptr; the lowest set bit is the round-robin winner.
  always_comb begin
    dbl = {i_req_valid, i_req_valid} >> rr_q;
    any = 1'b0;
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (dbl[i]) begin
        any = 1'b1;
        off = TW'(i);
      end
    gsum = {1'b0, rr_q} + {1'b0, off};
    gnt_idx = gsum >= (TW+1)'(N_REQ) ? TW'(gsum - (TW+1)'(N_REQ)) : gsum[TW-1:0];
    grant = any && !full && i_rst_n;
    o_req_ready = grant ? N_REQ'(1) << gnt_idx : '0;
    rr_d = grant ? (gnt_idx == TW'(N_REQ - 1) ? '0 : gnt_idx + TW'(1)) : rr_q;
    creq_d = grant ? i_req[gnt_idx] : creq_q;
    cready_d = grant;
    pop = i_cordic_valid && !empty;
    rsp_d = pop ? i_cordic_rsp : rsp_q;
    rsp_valid_d = pop ? N_REQ'(1) << tag : '0;
    err_d = err_q || (i_cordic_valid && empty);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      rr_q <= '0;
      creq_q <= '0;
      cready_q <= 1'b0;
      rsp_q <= '0;
      rsp_valid_q <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
      creq_q <= creq_d;
      cready_q <= cready_d;
      rsp_q <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      err_q <= err_d;
    end
  cordic_tag_fifo #(.W(TW), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (grant),
    .i_data  (gnt_idx),
    .i_pop   (pop),
    .o_data  (tag),
    .o_empty (empty),
    .o_full  (full),
    .o_count (count)
  );
  assign o_cordic_req = creq_q;
  assign o_cordic_ready = cready_q;
  assign o_rsp = rsp_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_err = err_q;
  assign o_busy = count != '0;
`ifdef CORDIC_ARB_PERF_EN
  logic [N_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N_REQ; i++)
      if (o_req_ready[i] && !(&cnt_q[i])) cnt_d[i] = cnt_q[i] + CNT_W'(1);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign o_grant_count = cnt_q;
`else
  assign o_grant_count = '0;
`endif
endmodule
